// File: rtl/gpio_bank_pkg.sv
// Shared constants and helpers for the multi-port GPIO bank.
package gpio_bank_pkg;

  // Register offsets inside one port's four-address window
  localparam int REG_DATA      = 0;
  localparam int REG_DIR       = 1;
  localparam int REG_EVENT     = 2;
  localparam int REG_EDGEEN    = 3;
  localparam int REGS_PER_PORT = 4;

  // Edge capture modes
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  // Width of the IO bus data and address vectors
  localparam int BUS_WIDTH = 16;

  // Picks which of the detected transitions counts as an event for the mode
  function automatic logic edge_hit(input logic rise, input logic fall, input int mode);
    logic hit;
    case (mode)
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      default:   hit = rise | fall;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/gpio_bank_port.sv
// One GPIO port: input synchroniser, edge detection, the four port
// registers and the local read mux. Selects arrive already decoded.
module gpio_port
  import gpio_bank_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = EDGE_BOTH,
  parameter bit RESET_DIR   = 1'b0
) (
  input  logic                     clk,
  input  logic                     resetq,
  input  logic                     write_enable,
  input  logic [REGS_PER_PORT-1:0] reg_sel,
  input  logic [WIDTH-1:0]         write_data,
  input  logic [WIDTH-1:0]         pin_in,
  output logic [WIDTH-1:0]         read_data,
  output logic [WIDTH-1:0]         pin_out,
  output logic [WIDTH-1:0]         pin_oe,
  output logic                     event_any
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] event_q, event_d;
  logic [WIDTH-1:0] edgeen_q, edgeen_d;
  logic [WIDTH-1:0] sync_val;
  logic [WIDTH-1:0] edge_seen;
  logic [REGS_PER_PORT-1:0] reg_wr;

  assign reg_wr   = {REGS_PER_PORT{write_enable}} & reg_sel;
  assign sync_val = sync_q[SYNC_STAGES-1];

  // Shift the raw pads through the synchroniser and remember last cycle's value
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_in};
    prev_d = sync_val;
  end

  // Per-pin transition detect on the synchronised value, filtered by edge mode
  always_comb begin
    edge_seen = '0;
    for (int i = 0; i < WIDTH; i++) begin
      edge_seen[i] = edge_hit(sync_val[i] & ~prev_q[i], ~sync_val[i] & prev_q[i], EDGE_MODE);
    end
  end

  // Register next-state: plain writes, W1C on events with a new edge taking priority
  always_comb begin
    out_d    = out_q;
    dir_d    = dir_q;
    edgeen_d = edgeen_q;
    if (reg_wr[REG_DATA]) begin
      out_d = write_data;
    end
    if (reg_wr[REG_DIR]) begin
      dir_d = write_data;
    end
    if (reg_wr[REG_EDGEEN]) begin
      edgeen_d = write_data;
    end
    event_d = (event_q & ~(write_data & {WIDTH{reg_wr[REG_EVENT]}})) | (edge_seen & edgeen_q);
  end

  // State flops; reset puts every register and the input history back to idle at once
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      sync_q   <= '0;
      prev_q   <= '0;
      out_q    <= '0;
      dir_q    <= {WIDTH{RESET_DIR}};
      event_q  <= '0;
      edgeen_q <= '0;
    end else begin
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      out_q    <= out_d;
      dir_q    <= dir_d;
      event_q  <= event_d;
      edgeen_q <= edgeen_d;
    end
  end

  // Local read mux; DATA returns the pad (synchronised), several selects OR together
  always_comb begin
    read_data = '0;
    if (reg_sel[REG_DATA]) begin
      read_data = read_data | sync_val;
    end
    if (reg_sel[REG_DIR]) begin
      read_data = read_data | dir_q;
    end
    if (reg_sel[REG_EVENT]) begin
      read_data = read_data | event_q;
    end
    if (reg_sel[REG_EDGEEN]) begin
      read_data = read_data | edgeen_q;
    end
  end

  assign pin_out   = out_q;
  assign pin_oe    = dir_q;
  assign event_any = |event_q;

endmodule

// File: rtl/gpio_bank.sv
// Multi-port GPIO peripheral on the one-hot IO bus. Slices the address
// into per-port register selects, ORs read data and interrupt flags.
// Bus vectors are [0:15]: element 15 is the numeric LSB, which is pin 0.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int NPORTS      = 2,
  parameter int WIDTH       = 8,
  parameter int BASE_BIT    = 0,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = EDGE_BOTH,
  parameter bit RESET_DIR   = 1'b0
) (
  input  logic                    clk,
  input  logic                    resetq,
  input  logic                    io_write_enable,
  input  logic                    io_read_enable,
  input  logic [0:15]             io_address,
  input  logic [0:15]             io_write_data,
  output logic [0:15]             io_read_data,
  input  logic [NPORTS*WIDTH-1:0] pin_in,
  output logic [NPORTS*WIDTH-1:0] pin_out,
  output logic [NPORTS*WIDTH-1:0] pin_oe,
  output logic                    irq,
  output logic [NPORTS-1:0]       irq_port
);

  if (NPORTS < 1 || NPORTS > 4) begin : g_bad_nports
    $error("gpio_bank: NPORTS must be 1..4");
  end
  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("gpio_bank: WIDTH must be 1..16");
  end
  if (BASE_BIT < 0 || BASE_BIT + REGS_PER_PORT * NPORTS > BUS_WIDTH) begin : g_bad_base
    $error("gpio_bank: BASE_BIT + 4*NPORTS must not exceed 16");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("gpio_bank: SYNC_STAGES must be 2..3");
  end
  if (EDGE_MODE < EDGE_RISE || EDGE_MODE > EDGE_BOTH) begin : g_bad_edge
    $error("gpio_bank: EDGE_MODE must be 0..2");
  end

  logic [BUS_WIDTH-1:0] wdata_num;
  logic [BUS_WIDTH-1:0] rdata_num;
  logic [WIDTH-1:0]     port_rdata [NPORTS];
  logic                 unused_bus;

  // Numeric view of the bus data: bit k is pin k
  assign wdata_num = io_write_data;

  // Reads have no side effects, so the read strobe and unowned bits are not needed
  assign unused_bus = ^{io_read_enable, io_address, wdata_num};

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic [REGS_PER_PORT-1:0] reg_sel;

    // Pick this port's four one-hot address bits
    always_comb begin
      reg_sel = '0;
      for (int r = 0; r < REGS_PER_PORT; r++) begin
        reg_sel[r] = io_address[BASE_BIT + REGS_PER_PORT * p + r];
      end
    end

    gpio_port #(
      .WIDTH      (WIDTH),
      .SYNC_STAGES(SYNC_STAGES),
      .EDGE_MODE  (EDGE_MODE),
      .RESET_DIR  (RESET_DIR)
    ) u_port (
      .clk         (clk),
      .resetq      (resetq),
      .write_enable(io_write_enable),
      .reg_sel     (reg_sel),
      .write_data  (wdata_num[WIDTH-1:0]),
      .pin_in      (pin_in[p*WIDTH +: WIDTH]),
      .read_data   (port_rdata[p]),
      .pin_out     (pin_out[p*WIDTH +: WIDTH]),
      .pin_oe      (pin_oe[p*WIDTH +: WIDTH]),
      .event_any   (irq_port[p])
    );
  end

  // OR every port's read data onto the low bits; unused high bits stay zero
  always_comb begin
    rdata_num = '0;
    for (int p = 0; p < NPORTS; p++) begin
      rdata_num[WIDTH-1:0] = rdata_num[WIDTH-1:0] | port_rdata[p];
    end
  end

  assign io_read_data = rdata_num;
  assign irq          = |irq_port;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed scoreboard bench for gpio_bank (2 ports x 8 pins, rising edges).
module tb_gpio_bank;

  typedef enum int {K_READ, K_PINOUT, K_PINOE, K_IRQ} kind_e;
  typedef struct {
    kind_e       kind;
    logic [15:0] val;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        io_write_enable = 1'b0;
  logic        io_read_enable = 1'b0;
  logic [0:15] io_address = '0;
  logic [0:15] io_write_data = '0;
  logic [0:15] io_read_data;
  logic [15:0] pin_in = '0;
  logic [15:0] pin_out;
  logic [15:0] pin_oe;
  logic        irq;
  logic [1:0]  irq_port;

  int   total = 0;
  int   bad = 0;
  exp_t sbQ[$];
  exp_t cur;
  logic [15:0] act;

  always #5 clk = ~clk;

  gpio_bank #(
    .NPORTS(2), .WIDTH(8), .BASE_BIT(0), .SYNC_STAGES(2), .EDGE_MODE(0), .RESET_DIR(1'b0)
  ) dut (
    .clk            (clk),
    .resetq         (resetq),
    .io_write_enable(io_write_enable),
    .io_read_enable (io_read_enable),
    .io_address     (io_address),
    .io_write_data  (io_write_data),
    .io_read_data   (io_read_data),
    .pin_in         (pin_in),
    .pin_out        (pin_out),
    .pin_oe         (pin_oe),
    .irq            (irq),
    .irq_port       (irq_port)
  );

  // Monitor: every read strobe presents an output, pop the oldest expectation and compare
  always @(negedge clk) begin
    if (io_read_enable) begin
      total++;
      if (sbQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_read actual=%h required=none", io_read_data);
      end else begin
        cur = sbQ.pop_front();
        case (cur.kind)
          K_READ:   act = io_read_data;
          K_PINOUT: act = pin_out;
          K_PINOE:  act = pin_oe;
          default:  act = {13'd0, irq, irq_port};
        endcase
        if (act !== cur.val) begin
          bad++;
          $display("[TB] FAIL %s actual=%h required=%h", cur.name, act, cur.val);
        end
      end
    end
  end

  function automatic logic [0:15] oneHot(input int idx);
    logic [0:15] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [0:15] sel, input logic [15:0] data);
    io_address      = sel;
    io_write_data   = data;
    io_write_enable = 1'b1;
    tick(1);
    io_write_enable = 1'b0;
    io_address      = '0;
    io_write_data   = '0;
  endtask

  task automatic checkOutput(input kind_e kind, input logic [0:15] sel,
                             input logic [15:0] expv, input string name);
    exp_t e;
    e.kind = kind;
    e.val  = expv;
    e.name = name;
    sbQ.push_back(e);
    io_address     = sel;
    io_read_enable = 1'b1;
    tick(1);
    io_read_enable = 1'b0;
    io_address     = '0;
  endtask

  // Watchdog so the bench always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [0:15] both;
    // Register index: port p reg r -> 4*p + r (DATA, DIR, EVENT, EDGEEN)
    tick(3);
    resetq = 1'b1;
    tick(1);

    $display("[TB] reset state");
    for (int i = 0; i < 8; i++) begin
      checkOutput(K_READ, oneHot(i), 16'h0000, $sformatf("reset_reg%0d", i));
    end
    checkOutput(K_PINOUT, '0, 16'h0000, "reset_pin_out");
    checkOutput(K_PINOE, '0, 16'h0000, "reset_pin_oe");
    checkOutput(K_IRQ, '0, 16'h0000, "reset_irq");

    $display("[TB] output latch and direction");
    applyStimulus(oneHot(1), 16'h00FF);
    applyStimulus(oneHot(0), 16'h00A5);
    checkOutput(K_PINOUT, '0, 16'h00A5, "p0_pin_out");
    checkOutput(K_PINOE, '0, 16'h00FF, "p0_pin_oe");
    checkOutput(K_READ, oneHot(1), 16'h00FF, "p0_dir_read");
    checkOutput(K_READ, oneHot(0), 16'h0000, "p0_data_reads_pad");
    applyStimulus(oneHot(5), 16'hFFFF);
    checkOutput(K_READ, oneHot(5), 16'h00FF, "p1_dir_high_bits");
    applyStimulus(oneHot(5), 16'h0000);

    $display("[TB] rising edge latency");
    applyStimulus(oneHot(7), 16'h0001);
    pin_in[8] = 1'b1;
    checkOutput(K_IRQ, '0, 16'h0000, "edge_lat_c0");
    checkOutput(K_IRQ, '0, 16'h0000, "edge_lat_c1");
    checkOutput(K_IRQ, '0, 16'h0000, "edge_lat_c2");
    checkOutput(K_IRQ, '0, 16'h0006, "edge_lat_c3");
    checkOutput(K_READ, oneHot(6), 16'h0001, "p1_event_set");
    checkOutput(K_READ, oneHot(4), 16'h0001, "p1_data_pad");

    $display("[TB] set wins over clear");
    pin_in[8] = 1'b0;
    tick(4);
    pin_in[8] = 1'b1;
    tick(2);
    applyStimulus(oneHot(6), 16'h0001);
    checkOutput(K_READ, oneHot(6), 16'h0001, "set_wins");
    applyStimulus(oneHot(6), 16'h0001);
    checkOutput(K_READ, oneHot(6), 16'h0000, "w1c_clears");
    checkOutput(K_IRQ, '0, 16'h0000, "irq_after_clear");
    pin_in[8] = 1'b0;
    tick(4);
    checkOutput(K_READ, oneHot(6), 16'h0000, "falling_ignored");

    $display("[TB] masked edge is lost");
    pin_in[0] = 1'b1;
    checkOutput(K_READ, oneHot(0), 16'h0000, "data_lag0");
    checkOutput(K_READ, oneHot(0), 16'h0000, "data_lag1");
    checkOutput(K_READ, oneHot(0), 16'h0001, "data_lag2");
    pin_in[0] = 1'b0;
    tick(4);
    applyStimulus(oneHot(3), 16'h0001);
    checkOutput(K_READ, oneHot(2), 16'h0000, "no_pending_edge");

    $display("[TB] mask clear keeps flag");
    pin_in[0] = 1'b1;
    tick(4);
    checkOutput(K_READ, oneHot(2), 16'h0001, "p0_event_set");
    applyStimulus(oneHot(3), 16'h0000);
    checkOutput(K_READ, oneHot(2), 16'h0001, "flag_kept_mask_off");
    applyStimulus(oneHot(2), 16'h0000);
    checkOutput(K_READ, oneHot(2), 16'h0001, "w0_leaves_flag");
    applyStimulus(oneHot(2), 16'h0001);
    checkOutput(K_READ, oneHot(2), 16'h0000, "p0_w1c");
    pin_in[0] = 1'b0;
    tick(3);

    $display("[TB] multi-select access");
    pin_in = 16'hF00F;
    both = oneHot(0) | oneHot(4);
    applyStimulus(both, 16'h1234);
    checkOutput(K_PINOUT, '0, 16'h3434, "multi_write_latches");
    checkOutput(K_READ, both, 16'h00FF, "multi_read_data_or");
    checkOutput(K_READ, oneHot(0), 16'h000F, "p0_data_only");
    checkOutput(K_READ, oneHot(1) | oneHot(5), 16'h00FF, "multi_read_dir_or");

    $display("[TB] reset mid-operation");
    resetq = 1'b0;
    checkOutput(K_PINOUT, '0, 16'h0000, "midreset_pin_out");
    checkOutput(K_PINOE, '0, 16'h0000, "midreset_pin_oe");
    checkOutput(K_IRQ, '0, 16'h0000, "midreset_irq");
    resetq = 1'b1;
    tick(1);
    checkOutput(K_READ, oneHot(7), 16'h0000, "midreset_edgeen");

    tick(2);
    if (sbQ.size() != 0) begin
      bad += sbQ.size();
      total += sbQ.size();
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sbQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
